// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_BYTE_W : width of one UART data byte.
//   txf_state_e : launch FSM state encoding used by uart_tx_fifo.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE      = 2'd0,
    TXF_LAUNCH    = 2'd1,
    TXF_WAIT_BUSY = 2'd2,
    TXF_WAIT_DONE = 2'd3
  } txf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with occupancy count and sticky overflow flag.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, wr_data : write request and byte; ignored (and flagged) when full
//   pop, rd_data  : read request; rd_data always shows the head entry
//   full, empty   : decoded from the registered count
//   count         : occupancy 0..DEPTH
//   overflow      : sticky, set when a push is dropped
//   clr_overflow  : clears overflow; a drop in the same cycle takes priority
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam logic [ADDR_W:0] FullCnt = DEPTH[ADDR_W:0];

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]        count_q;
  logic                   overflow_q;
  logic                   do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Pointers are ADDR_W wide so they wrap DEPTH-1 -> 0 on their own.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
      // full is the pre-edge value, so a same-cycle pop cannot rescue the byte.
      if (push && full) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART core. Bytes are pushed at full clock
// rate into a FIFO and launched one at a time into the UART, pacing on
// is_transmitting.
// Ports:
//   clk, rst          : clock shared with the UART, async active-low reset
//   wr_en, wr_data    : push interface
//   full, empty       : FIFO status
//   count             : FIFO occupancy 0..DEPTH
//   overflow          : sticky dropped-push flag, cleared by clr_overflow
//   tx_enable         : when low, no new byte is launched from IDLE
//   tx_timeout        : one-cycle pulse when the UART never went busy
//   transmit, tx_byte : registered launch pulse and byte to the UART
//   is_transmitting   : UART busy flag
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BUSY_TIMEOUT = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clr_overflow,
  input  logic                   tx_enable,
  output logic                   tx_timeout,
  output logic                   transmit,
  output logic [UART_BYTE_W-1:0] tx_byte,
  input  logic                   is_transmitting
);

  localparam int unsigned     TimerW    = $clog2(BUSY_TIMEOUT + 1);
  // Timeout fires on the edge where the timer would reach BUSY_TIMEOUT.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BUSY_TIMEOUT - 1);

  txf_state_e             state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   transmit_q, transmit_d;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic                   tx_timeout_q, tx_timeout_d;
  logic [UART_BYTE_W-1:0] fifo_rd_data;
  logic                   launch;
  logic                   busy_expired;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (wr_en),
    .wr_data      (wr_data),
    .pop          (launch),
    .rd_data      (fifo_rd_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  assign launch = (state_q == TXF_IDLE) && !empty && tx_enable && !is_transmitting;
  assign busy_expired = (state_q == TXF_WAIT_BUSY) && !is_transmitting &&
                        (timer_q == TimerLast);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TXF_IDLE;
      timer_q      <= '0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      transmit_q   <= transmit_d;
      tx_byte_q    <= tx_byte_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TXF_IDLE:      if (launch) state_d = TXF_LAUNCH;
      TXF_LAUNCH:    state_d = TXF_WAIT_BUSY;
      TXF_WAIT_BUSY: begin
        if (is_transmitting) begin
          state_d = TXF_WAIT_DONE;
        end else if (busy_expired) begin
          // Byte is abandoned, not re-queued.
          state_d = TXF_IDLE;
        end
      end
      TXF_WAIT_DONE: if (!is_transmitting) state_d = TXF_IDLE;
      default:       state_d = TXF_IDLE;
    endcase
  end

  // Next values of the registered outputs and timer.
  always_comb begin
    transmit_d   = launch;
    tx_byte_d    = launch ? fifo_rd_data : tx_byte_q;
    tx_timeout_d = busy_expired;
    timer_d      = timer_q;
    case (state_q)
      TXF_LAUNCH:    timer_d = '0;
      TXF_WAIT_BUSY: if (!is_transmitting) timer_d = timer_q + 1'b1;
      default:       timer_d = timer_q;
    endcase
  end

  assign transmit   = transmit_q;
  assign tx_byte    = tx_byte_q;
  assign tx_timeout = tx_timeout_q;

endmodule
